// File: rtl/vga_layer_compositor.sv
// Priority compositor for N_LAYERS panel outputs with a 2-stage pipeline and page-transition blanking.
// Optional fade-in during transitions when VGA_LAYER_FADE_EN is defined.
module vga_layer_compositor #(
    parameter int unsigned N_LAYERS    = 10,
    parameter int unsigned CH_W        = 8,
    parameter logic [3*CH_W-1:0] BG_COLOR = 24'hFFFFFF,
    parameter int unsigned MODE_W      = 8,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic                           vga_clk,
    input  logic                           rst_n,
    input  logic [MODE_W-1:0]              mode,
    input  logic                           frame_start,
    input  logic [N_LAYERS-1:0]            layer_en,
    input  logic [N_LAYERS*3*CH_W-1:0]     layer_data,
    output logic [3*CH_W-1:0]              pos_data,
    output logic [$clog2(N_LAYERS+1)-1:0]  layer_sel,
    output logic                           transition_busy
);

    localparam int unsigned PIX_W    = 3 * CH_W;
    localparam int unsigned SEL_W    = $clog2(N_LAYERS + 1);
    localparam int unsigned CNT_W    = (HOLD_FRAMES == 0) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam int unsigned HF_LAST  = (HOLD_FRAMES == 0) ? 0 : HOLD_FRAMES - 1;
    localparam bit          TRANS_EN = (HOLD_FRAMES != 0);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [MODE_W-1:0]  r_mode_q;
    logic [SEL_W-1:0]   r_win_idx;
    logic [PIX_W-1:0]   r_win_data;

    logic [SEL_W-1:0]   w_win_idx;
    logic [PIX_W-1:0]   w_win_data;
    logic [PIX_W-1:0]   w_hold_data;
    logic               w_mode_chg;

    assign w_mode_chg = (mode != r_mode_q);

    // Lowest enabled index wins; scan high-to-low so the last hit is the winner.
    always_comb begin
        w_win_idx  = SEL_W'(N_LAYERS);
        w_win_data = BG_COLOR;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i]) begin
                w_win_idx  = SEL_W'(i);
                w_win_data = layer_data[i*PIX_W +: PIX_W];
            end
        end
    end

`ifdef VGA_LAYER_FADE_EN
    localparam int unsigned SH_W = $clog2(CH_W + 1);

    logic [31:0]      w_remain;
    logic [SH_W-1:0]  w_shift;

    // Shift shrinks as the transition progresses, giving a fade-in from dark.
    always_comb begin
        w_remain    = HOLD_FRAMES - 32'(r_frame_cnt);
        w_shift     = (w_remain < CH_W) ? SH_W'(w_remain) : SH_W'(CH_W);
        w_hold_data = '0;
        for (int c = 0; c < 3; c++) begin
            w_hold_data[c*CH_W +: CH_W] = r_win_data[c*CH_W +: CH_W] >> w_shift;
        end
    end
`else
    assign w_hold_data = BG_COLOR;
`endif

    // Stage 1 (winner select) and stage 2 (blanking/fade on output).
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            r_win_idx  <= SEL_W'(N_LAYERS);
            r_win_data <= BG_COLOR;
            layer_sel  <= SEL_W'(N_LAYERS);
            pos_data   <= BG_COLOR;
        end else begin
            r_win_idx  <= w_win_idx;
            r_win_data <= w_win_data;
            layer_sel  <= r_win_idx;
            pos_data   <= (r_state == ST_HOLD) ? w_hold_data : r_win_data;
        end
    end

    // Page-transition sequencer; a mode change always restarts the frame count.
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_frame_cnt     <= '0;
            r_mode_q        <= mode;
            transition_busy <= 1'b0;
        end else begin
            r_mode_q <= mode;
            case (r_state)
                ST_IDLE: begin
                    if (w_mode_chg && TRANS_EN) begin
                        r_state         <= ST_HOLD;
                        r_frame_cnt     <= '0;
                        transition_busy <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_mode_chg) begin
                        r_frame_cnt <= '0;
                    end else if (frame_start) begin
                        if (r_frame_cnt == CNT_W'(HF_LAST)) begin
                            r_state         <= ST_IDLE;
                            r_frame_cnt     <= '0;
                            transition_busy <= 1'b0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_frame_cnt     <= '0;
                    transition_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
